// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (CPU Memory stage, pixel fetcher)
// and the byte-wide data RAM.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int OFS_W  = 14
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_two_byte;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] cpu_wdata;
  logic [ADDR_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              disp_req;
  logic [3:0]        cuadrante;
  logic [OFS_W-1:0]  disp_offset;
  logic [7:0]        pixel;
  logic              disp_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_two_byte, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  disp_req, cuadrante, disp_offset,
    output pixel, disp_ack,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_two_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output disp_req, cuadrante, disp_offset,
    input  pixel, disp_ack,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the byte-wide data RAM between CPU loads/stores (1 or 2 bytes,
// little-endian, split into byte cycles) and the pixel fetcher.
//   state | meaning
//   IDLE  | no RAM access; arbitrate and latch the granted request
//   C_LO  | CPU byte at A
//   C_HI  | CPU byte at A+1; low read byte arrives
//   C_END | last CPU read byte arrives; done pulses next cycle
//   D_RD  | pixel byte read
//   D_END | pixel byte arrives; ack pulses next cycle
module mem_port_arbiter #(
  parameter int                ADDR_W    = 19,
  parameter logic [ADDR_W-1:0] PIX_BASE  = 19'h10000,
  parameter logic [ADDR_W-1:0] QUAD_SIZE = 19'h4000,
  parameter int                OFS_W     = 14
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, C_LO, C_HI, C_END, D_RD, D_END} state_t;

  state_t            state, state_nxt;
  logic              last_grant;  // 0 = CPU, 1 = display
  logic              cpu_elig, disp_elig;
  logic              grant_cpu, grant_disp;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] cpu_rdata_reg;
  logic              we_reg, two_reg;
  logic [15:0]       wdata_reg;
  logic [7:0]        lo_reg, pixel_reg;
  logic              cpu_done_reg, disp_ack_reg;
  logic              unused_wdata_hi;

  assign unused_wdata_hi = ^bus.cpu_wdata[ADDR_W-1:16];

  // A request whose completion pulse is showing this cycle is the one just served.
  assign cpu_elig  = bus.cpu_req  & ~cpu_done_reg;
  assign disp_elig = bus.disp_req & ~disp_ack_reg;
  assign pix_addr  = PIX_BASE + ADDR_W'(bus.cuadrante) * QUAD_SIZE + ADDR_W'(bus.disp_offset);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    grant_cpu     = 1'b0;
    grant_disp    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (state)
      IDLE: begin
        if (cpu_elig && (!disp_elig || last_grant)) begin
          grant_cpu = 1'b1;
          state_nxt = C_LO;
        end else if (disp_elig) begin
          grant_disp = 1'b1;
          state_nxt  = D_RD;
        end
      end
      C_LO: begin
        bus.ram_addr  = addr_reg;
        bus.ram_we    = we_reg;
        bus.ram_wdata = wdata_reg[7:0];
        state_nxt     = two_reg ? C_HI : C_END;
      end
      C_HI: begin
        bus.ram_addr  = addr_reg + ADDR_W'(1);
        bus.ram_we    = we_reg;
        bus.ram_wdata = wdata_reg[15:8];
        state_nxt     = C_END;
      end
      C_END: state_nxt = IDLE;
      D_RD: begin
        bus.ram_addr = addr_reg;
        state_nxt    = D_END;
      end
      D_END:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant    <= 1'b0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      two_reg       <= 1'b0;
      wdata_reg     <= '0;
      lo_reg        <= '0;
      cpu_rdata_reg <= '0;
      cpu_done_reg  <= 1'b0;
      pixel_reg     <= '0;
      disp_ack_reg  <= 1'b0;
    end else begin
      cpu_done_reg <= 1'b0;
      disp_ack_reg <= 1'b0;
      if (grant_cpu) begin
        addr_reg   <= bus.cpu_addr;
        we_reg     <= bus.cpu_we;
        two_reg    <= bus.cpu_two_byte;
        wdata_reg  <= bus.cpu_wdata[15:0];
        last_grant <= 1'b0;
      end
      if (grant_disp) begin
        addr_reg   <= pix_addr;
        last_grant <= 1'b1;
      end
      if (state == C_HI) lo_reg <= bus.ram_rdata;
      if (state == C_END) begin
        cpu_done_reg <= 1'b1;
        if (!we_reg)
          cpu_rdata_reg <= two_reg ? ADDR_W'({bus.ram_rdata, lo_reg}) : ADDR_W'(bus.ram_rdata);
      end
      if (state == D_END) begin
        pixel_reg    <= bus.ram_rdata;
        disp_ack_reg <= 1'b1;
      end
    end
  end

  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_done  = cpu_done_reg;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_reg;
  assign bus.pixel     = pixel_reg;
  assign bus.disp_ack  = disp_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural byte RAM, directed accesses,
// monitor pops expected responses on every cpu_done / disp_ack.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<19)-1];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct packed {
    logic        is_disp;
    logic [18:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_disp, input logic [18:0] data);
    exp_t e;
    e.is_disp = is_disp;
    e.data    = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.cpu_done || bus.disp_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got done=%b ack=%b expected none at %0t",
                 bus.cpu_done, bus.disp_ack, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_kind", {31'b0, bus.disp_ack}, {31'b0, mon_e.is_disp});
        if (mon_e.is_disp) chk("pixel", {24'b0, bus.pixel}, {24'b0, mon_e.data[7:0]});
        else               chk("cpu_rdata", {13'b0, bus.cpu_rdata}, {13'b0, mon_e.data});
      end
    end
  end

  task automatic cpu_access(input logic we, input logic two, input logic [18:0] addr,
                            input logic [18:0] wdata, input logic [18:0] exp_rdata,
                            input int exp_lat);
    int k;
    bit seen;
    push_exp(1'b0, exp_rdata);
    bus.cpu_we       = we;
    bus.cpu_two_byte = two;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.cpu_req      = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (bus.cpu_done) seen = 1;
      else chk("stall_high", {31'b0, bus.cpu_stall}, 32'd1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got no cpu_done expected one within 20 cycles");
    end else begin
      chk("cpu_latency", k, exp_lat);
      chk("stall_low_at_done", {31'b0, bus.cpu_stall}, 32'd0);
    end
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic disp_fetch(input logic [3:0] quad, input logic [13:0] ofs,
                            input logic [18:0] exp_addr, input logic [7:0] exp_pix);
    int k;
    bit seen;
    push_exp(1'b1, {11'b0, exp_pix});
    bus.cuadrante   = quad;
    bus.disp_offset = ofs;
    bus.disp_req    = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      chk("disp_ram_we", {31'b0, bus.ram_we}, 32'd0);
      if (k == 1) chk("disp_ram_addr", {13'b0, bus.ram_addr}, {13'b0, exp_addr});
      if (bus.disp_ack) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL disp_timeout: got no disp_ack expected one within 20 cycles");
    end else chk("disp_latency", k, 3);
    bus.disp_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both requesters raised together; display is expected first, CPU right after.
  task automatic both_round(input logic two, input logic [18:0] addr, input logic [18:0] exp_rdata,
                            input logic [3:0] quad, input logic [13:0] ofs,
                            input logic [7:0] exp_pix, input int exp_cpu_cycle);
    int k;
    bit cd, dd;
    push_exp(1'b1, {11'b0, exp_pix});
    push_exp(1'b0, exp_rdata);
    bus.cpu_we       = 1'b0;
    bus.cpu_two_byte = two;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = '0;
    bus.cuadrante    = quad;
    bus.disp_offset  = ofs;
    bus.cpu_req      = 1'b1;
    bus.disp_req     = 1'b1;
    k = 0;
    cd = 0;
    dd = 0;
    while (!(cd && dd) && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (bus.disp_ack) begin
        chk("rr_disp_cycle", k, 3);
        bus.disp_req = 1'b0;
        dd = 1;
      end
      if (bus.cpu_done) begin
        chk("rr_cpu_cycle", k, exp_cpu_cycle);
        bus.cpu_req = 1'b0;
        cd = 1;
      end
    end
    if (!(cd && dd)) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout: got cpu_done_seen=%0d disp_ack_seen=%0d expected both", cd, dd);
    end
    bus.cpu_req  = 1'b0;
    bus.disp_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_done", {31'b0, bus.cpu_done}, 32'd0);
    chk("rst_disp_ack", {31'b0, bus.disp_ack}, 32'd0);
    chk("rst_cpu_rdata", {13'b0, bus.cpu_rdata}, 32'd0);
    chk("rst_pixel", {24'b0, bus.pixel}, 32'd0);
    chk("rst_ram_addr", {13'b0, bus.ram_addr}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;
    mem[19'h18005] = 8'h5A;
    mem[19'h10003] = 8'h77;
    mem[19'h17FFF] = 8'h99;
    mem[11]        = 8'hC3;

    reset            = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_two_byte = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    bus.disp_req     = 1'b0;
    bus.cuadrante    = '0;
    bus.disp_offset  = '0;
    @(posedge clk); #1;
    do_reset();

    // Two-byte store then load
    cpu_access(1'b1, 1'b1, 19'd6, 19'h0EEFF, 19'h00000, 4);
    chk("mem6_ff", {24'b0, mem[6]}, 32'hFF);
    chk("mem7_ee", {24'b0, mem[7]}, 32'hEE);
    cpu_access(1'b0, 1'b1, 19'd6, 19'h0, 19'h0EEFF, 4);

    // Single-byte store, mixed-width loads
    cpu_access(1'b1, 1'b0, 19'd6, 19'h000BB, 19'h0EEFF, 3);
    chk("mem7_kept", {24'b0, mem[7]}, 32'hEE);
    cpu_access(1'b0, 1'b1, 19'd6, 19'h0, 19'h0EEBB, 4);
    cpu_access(1'b0, 1'b0, 19'd7, 19'h0, 19'h000EE, 3);

    // Pixel fetch from quadrant 2
    disp_fetch(4'd2, 14'd5, 19'h18005, 8'h5A);

    // Address wrap at the top of the RAM
    cpu_access(1'b1, 1'b1, 19'h7FFFF, 19'h01234, 19'h000EE, 4);
    chk("mem_top_34", {24'b0, mem[19'h7FFFF]}, 32'h34);
    chk("mem_zero_12", {24'b0, mem[0]}, 32'h12);
    cpu_access(1'b0, 1'b1, 19'h7FFFF, 19'h0, 19'h01234, 4);

    // Round-robin from reset: display wins the first tie, then alternation
    do_reset();
    both_round(1'b0, 19'd6, 19'h000BB, 4'd0, 14'd3, 8'h77, 6);
    both_round(1'b1, 19'd6, 19'h0EEBB, 4'd1, 14'h3FFF, 8'h99, 7);

    // Reset during the high-byte cycle of a two-byte store
    bus.cpu_we       = 1'b1;
    bus.cpu_two_byte = 1'b1;
    bus.cpu_addr     = 19'd10;
    bus.cpu_wdata    = 19'h0AA55;
    bus.cpu_req      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("chi_ram_we", {31'b0, bus.ram_we}, 32'd1);
    chk("chi_ram_addr", {13'b0, bus.ram_addr}, 32'd11);
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("midop_ram_we", {31'b0, bus.ram_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midop_no_done", {31'b0, bus.cpu_done}, 32'd0);
      chk("midop_idle_addr", {13'b0, bus.ram_addr}, 32'd0);
    end
    chk("midop_mem10", {24'b0, mem[10]}, 32'h55);
    chk("midop_mem11", {24'b0, mem[11]}, 32'hC3);
    cpu_access(1'b0, 1'b1, 19'd10, 19'h0, 19'h0C355, 4);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single byte-wide data RAM between two requesters: the pipeline Memory stage (CPU loads/stores of 1 or 2 bytes) and the pixel fetcher that reads image bytes from a selected quadrant.
- Each 2-byte CPU access is split into two single-byte RAM cycles.
- The CPU is stalled until its access completes.
- Arbitration between the two requesters is round-robin.

Parameters:
ADDR_W, 19, RAM byte-address width
PIX_BASE, 19'h10000, byte address of quadrant 0 of the image
QUAD_SIZE, 19'h4000, bytes per quadrant (128x128)
OFS_W, 14, width of the pixel offset within a quadrant

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
cpu_req  in  1  Memory-stage access request; held until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_two_byte  in  1  1 = 2-byte access, 0 = 1-byte access
cpu_addr  in  19  byte address
cpu_wdata  in  19  store data; only [15:0] used
cpu_rdata  out  19  load data, zero-extended; valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_stall  out  1  pipeline stall = cpu_req & ~cpu_done (combinational)
disp_req  in  1  pixel fetch request; held until disp_ack
cuadrante  in  4  quadrant select
disp_offset  in  14  byte offset inside the quadrant
pixel  out  8  fetched pixel byte
disp_ack  out  1  one-cycle pulse; pixel valid in this cycle
ram_addr  out  19  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read data; synchronous, 1-cycle latency

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cpu_done=0; disp_ack=0; cpu_rdata=0; pixel=0; last_grant=CPU; internal registers=0.
- RAM outputs are decoded combinationally from state and latched request, so ram_we falls immediately on reset.
- States: IDLE, C_LO, C_HI, C_END, D_RD, D_END.
- IDLE:
  - ram_we=0, ram_addr=0.
  - A requester is eligible only if its req=1 and its done/ack is not high this cycle (prevents re-accepting the same request).
  - Both eligible: grant the requester that is not last_grant.
  - On grant: latch addr, we, wdata, two_byte (CPU) or computed pixel address (display); update last_grant.
  - Next state: C_LO for CPU, D_RD for display.
- Little-endian byte order: the low byte is at A, the high byte at A+1.
- C_LO: ram_addr=A; ram_we=we; ram_wdata=wdata[7:0]. Next state: C_HI if two_byte, else C_END.
- C_HI:
  - ram_addr=A+1, modulo 2^19 (19'h7FFFF+1 = 0).
  - ram_we=we; ram_wdata=wdata[15:8].
  - Capture lo_reg <= ram_rdata.
  - Next state: C_END.
- C_END:
  - ram_we=0.
  - On the exit edge: cpu_rdata <= two_byte ? {3'b0, ram_rdata, lo_reg} : {11'b0, ram_rdata}; cpu_done <= 1.
  - Next state: IDLE.
  - On stores, cpu_rdata is left unchanged.
- D_RD: ram_addr = PIX_BASE + cuadrante*QUAD_SIZE + disp_offset, truncated to 19 bits and latched at grant; ram_we=0. Next state: D_END.
- D_END: on the exit edge, pixel <= ram_rdata and disp_ack <= 1. Next state: IDLE.
- cpu_done and disp_ack are high for exactly one cycle, in the following IDLE.
- Latency from grant cycle to done/ack cycle:
  - 1-byte CPU access: 3 cycles.
  - 2-byte CPU access: 4 cycles.
  - Display fetch: 3 cycles.
- Requester inputs must stay stable from request until done/ack. Changes after grant are ignored because the request is latched at grant.
- A request dropped before grant is never served; a request dropped after grant still completes.
- Reset mid-operation:
  - Transaction is abandoned; no done/ack pulse.
  - A 2-byte store interrupted in C_HI leaves only byte A written.
- No RAM access ever occurs in IDLE, C_END or D_END.

Test Plan:
1. Two-byte store 0x0EEFF at addr 6, then two-byte load from 6 -> mem[6]=FF, mem[7]=EE; cpu_rdata=19'h0EEFF; cpu_done 4 cycles after grant; cpu_stall high until done.
2. One-byte store 0x000BB at 6, two-byte load from 6, then one-byte load from 7 -> cpu_rdata=19'h0EEBB, then 19'h000EE.
3. Display fetch with cuadrante=2, disp_offset=5 -> ram_addr=19'h18005 in D_RD; pixel=mem[19'h18005]; disp_ack 3 cycles after grant; ram_we stays 0.
4. cpu_req and disp_req both high from reset, each held -> display served first, then CPU; re-raise both -> display, CPU again (alternation); cpu_req alone never waits more than one display transaction.
5. Two-byte store 0x01234 at 19'h7FFFF -> mem[7FFFF]=34, mem[00000]=12; load returns 19'h01234.
6. Assert reset during C_HI of a two-byte store of 0x0AA55 at 10 -> ram_we=0 immediately; no cpu_done; state=IDLE; mem[10]=55; mem[11] unchanged.
